// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and DDRAM row addressing for the character-LCD controller.
package lcd_pkg;

  localparam logic [7:0] FSET_8B_2L = 8'h38;
  localparam logic [7:0] FSET_8B_1L = 8'h30;
  localparam logic [7:0] DCTL_ON    = 8'h0C;
  localparam logic [7:0] CLR        = 8'h01;
  localparam logic [7:0] SET_DDRAM  = 8'h80;

  typedef enum logic [2:0] {
    S_PWR_WAIT,
    S_FSET,
    S_DCTL,
    S_CLR,
    S_IDLE,
    S_ADDR,
    S_CHAR
  } lcd_state_t;

  typedef enum logic [1:0] {
    PH_SETUP,
    PH_STROBE,
    PH_WAIT
  } lcd_phase_t;

  // Rows 2/3 continue rows 0/1 in DDRAM on 4-line panels.
  function automatic logic [7:0] row_base(input logic [1:0] row, input int unsigned cols);
    case (row)
      2'd0:    row_base = 8'h00;
      2'd1:    row_base = 8'h40;
      2'd2:    row_base = 8'(cols);
      default: row_base = 8'h40 + 8'(cols);
    endcase
  endfunction

endpackage

// File: rtl/lcd_us_tick.sv
// Free-running divider producing a one-clock pulse every microsecond.
module lcd_us_tick #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned DIV = (CLK_FREQ_HZ / 1_000_000 > 0) ? CLK_FREQ_HZ / 1_000_000 : 1;
  localparam int unsigned W   = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/lcd_text_ctrl.sv
// HD44780-class 8-bit write-only controller: power-on init, then refreshes rows of an
// internal character buffer whenever they are written (or continuously in auto mode).
module lcd_text_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ  = 100_000_000,
  parameter int unsigned ROWS         = 2,
  parameter int unsigned COLS         = 16,
  parameter int unsigned PWRON_US     = 20000,
  parameter int unsigned CMD_US       = 40,
  parameter int unsigned CLR_US       = 1640,
  parameter bit          AUTO_REFRESH = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [1:0] wr_row,
  input  logic [5:0] wr_col,
  input  logic [7:0] wr_char,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic       ready,
  output logic       busy
);

  localparam int unsigned NCHR   = ROWS * COLS;
  localparam int unsigned IW     = $clog2(NCHR);
  localparam int unsigned MAX_US = (PWRON_US > CLR_US) ? ((PWRON_US > CMD_US) ? PWRON_US : CMD_US)
                                                       : ((CLR_US > CMD_US) ? CLR_US : CMD_US);
  localparam int unsigned UW     = ($clog2(MAX_US + 1) > 15) ? $clog2(MAX_US + 1) : 15;
  localparam logic [2:0]  ROWS_L = 3'(ROWS);
  localparam logic [6:0]  COLS_L = 7'(COLS);
  localparam logic [5:0]  LAST_C = 6'(COLS - 1);

  function automatic logic [IW-1:0] buf_idx(input logic [1:0] r, input logic [5:0] c);
    return IW'(r) * IW'(COLS) + IW'(c);
  endfunction

  lcd_state_t      state, state_n;
  lcd_phase_t      phase, phase_n;
  logic [UW-1:0]   us_cnt, us_cnt_n, wait_last;
  logic [1:0]      row, row_n, rr_row, rr_row_n, sel_row;
  logic [5:0]      col, col_n;
  logic [7:0]      data_n;
  logic            rs_n, e_n, ready_n, any_dirty, tick, wr_ok;
  logic [ROWS-1:0] dirty, dirty_set, dirty_clr;
  logic [7:0]      char_buf [NCHR];

  lcd_us_tick #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign wr_ok  = wr_en && ({1'b0, wr_row} < ROWS_L) && ({1'b0, wr_col} < COLS_L);
  assign lcd_rw = 1'b0;
  assign busy   = !(state == S_IDLE && !any_dirty);

  always_comb begin
    dirty_set = '0;
    for (int unsigned i = 0; i < ROWS; i++)
      if (wr_ok && wr_row == 2'(i)) dirty_set[i] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NCHR; i++) char_buf[i] <= 8'h20;
    end else if (wr_ok) begin
      char_buf[buf_idx(wr_row, wr_col)] <= wr_char;
    end
  end

  always_comb begin
    state_n   = state;
    phase_n   = phase;
    us_cnt_n  = us_cnt;
    row_n     = row;
    col_n     = col;
    rr_row_n  = rr_row;
    data_n    = lcd_data;
    rs_n      = lcd_rs;
    e_n       = lcd_e;
    ready_n   = ready;
    dirty_clr = '0;
    sel_row   = '0;
    any_dirty = 1'b0;

    case (state)
      S_PWR_WAIT: wait_last = UW'(PWRON_US - 1);
      S_CLR:      wait_last = UW'(CLR_US - 1);
      default:    wait_last = UW'(CMD_US - 1);
    endcase

    if (AUTO_REFRESH) begin
      any_dirty = 1'b1;
      sel_row   = rr_row;
    end else begin
      for (int unsigned i = 0; i < ROWS; i++)
        if (dirty[i] && !any_dirty) begin
          any_dirty = 1'b1;
          sel_row   = 2'(i);
        end
    end

    if (state == S_IDLE) begin
      if (any_dirty) begin
        state_n  = S_ADDR;
        phase_n  = PH_SETUP;
        row_n    = sel_row;
        rr_row_n = (rr_row == 2'(ROWS - 1)) ? 2'd0 : rr_row + 2'd1;
        data_n   = SET_DDRAM | row_base(sel_row, COLS);
        rs_n     = 1'b0;
        for (int unsigned i = 0; i < ROWS; i++)
          if (2'(i) == sel_row) dirty_clr[i] = 1'b1;
      end
    end else if (tick) begin
      // Every command shares setup -> strobe -> wait; only the wait length and successor differ.
      case (phase)
        PH_SETUP: begin
          phase_n = PH_STROBE;
          e_n     = 1'b1;
        end
        PH_STROBE: begin
          phase_n  = PH_WAIT;
          e_n      = 1'b0;
          us_cnt_n = '0;
        end
        default: begin
          if (us_cnt != wait_last) begin
            us_cnt_n = us_cnt + UW'(1);
          end else begin
            phase_n = PH_SETUP;
            case (state)
              S_PWR_WAIT: begin
                state_n = S_FSET;
                data_n  = (ROWS == 1) ? FSET_8B_1L : FSET_8B_2L;
                rs_n    = 1'b0;
              end
              S_FSET: begin
                state_n = S_DCTL;
                data_n  = DCTL_ON;
              end
              S_DCTL: begin
                state_n = S_CLR;
                data_n  = CLR;
              end
              S_ADDR: begin
                state_n = S_CHAR;
                col_n   = '0;
                rs_n    = 1'b1;
                data_n  = char_buf[buf_idx(row, 6'd0)];
              end
              S_CHAR: begin
                if (col == LAST_C) begin
                  state_n = S_IDLE;
                end else begin
                  col_n  = col + 6'd1;
                  data_n = char_buf[buf_idx(row, col + 6'd1)];
                end
              end
              default: begin
                state_n = S_IDLE;
                ready_n = 1'b1;
              end
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_PWR_WAIT;
      phase    <= PH_WAIT;
      us_cnt   <= '0;
      row      <= '0;
      col      <= '0;
      rr_row   <= '0;
      lcd_data <= '0;
      lcd_rs   <= 1'b0;
      lcd_e    <= 1'b0;
      ready    <= 1'b0;
      dirty    <= '1;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      us_cnt   <= us_cnt_n;
      row      <= row_n;
      col      <= col_n;
      rr_row   <= rr_row_n;
      lcd_data <= data_n;
      lcd_rs   <= rs_n;
      lcd_e    <= e_n;
      ready    <= ready_n;
      // A write landing on the row being cleared keeps it dirty so it is resent.
      dirty    <= (dirty & ~dirty_clr) | dirty_set;
    end
  end

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Directed bench for lcd_text_ctrl with a scaled clock and short delays (4 clocks per us).
module tb_lcd_text_ctrl;

  localparam int unsigned CLK_HZ = 4_000_000;
  localparam int unsigned DIV    = 4;
  localparam int unsigned ROWS   = 2;
  localparam int unsigned COLS   = 16;
  localparam int unsigned PWRON  = 50;
  localparam int unsigned CMDW   = 3;
  localparam int unsigned CLRW   = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_row = '0;
  logic [5:0] wr_col = '0;
  logic [7:0] wr_char = '0;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_e, ready, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int fall_cyc = 0;
  logic e_q = 1'b0;
  logic [8:0] q [$];
  logic [7:0] mdl [ROWS][COLS];

  lcd_text_ctrl #(
    .CLK_FREQ_HZ (CLK_HZ),
    .ROWS        (ROWS),
    .COLS        (COLS),
    .PWRON_US    (PWRON),
    .CMD_US      (CMDW),
    .CLR_US      (CLRW),
    .AUTO_REFRESH(1'b0)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_char (wr_char),
    .lcd_data(lcd_data),
    .lcd_rs  (lcd_rs),
    .lcd_rw  (lcd_rw),
    .lcd_e   (lcd_e),
    .ready   (ready),
    .busy    (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Capture {rs,data} at every rising edge of the enable strobe.
  always @(negedge clk) begin
    if (lcd_e && !e_q) begin
      q.push_back({lcd_rs, lcd_data});
      rise_cyc = cyc;
    end
    if (!lcd_e && e_q) fall_cyc = cyc;
    e_q = lcd_e;
  end

  task automatic get_byte(output logic [8:0] b);
    int k = 0;
    b = 'x;
    while (q.size() == 0 && k < 1000) begin
      @(negedge clk); #1;
      k++;
    end
    if (q.size() != 0) b = q.pop_front();
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy !== 1'b0 && k < 3000) begin
      @(negedge clk); #1;
      k++;
    end
  endtask

  task automatic do_write(input int r, input int c, input logic [7:0] ch);
    @(negedge clk);
    wr_en = 1'b1; wr_row = 2'(r); wr_col = 6'(c); wr_char = ch;
    @(negedge clk);
    wr_en = 1'b0;
    if (r < ROWS && c < COLS) mdl[r][c] = ch;
  endtask

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) mdl[r][c] = 8'h20;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_tests++; if (lcd_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h, expected 00", lcd_data); end
    n_tests++; if (lcd_rs !== 1'b0) begin n_fail++; $display("FAIL reset_rs: got %b, expected 0", lcd_rs); end
    n_tests++; if (lcd_rw !== 1'b0) begin n_fail++; $display("FAIL reset_rw: got %b, expected 0", lcd_rw); end
    n_tests++; if (lcd_e !== 1'b0) begin n_fail++; $display("FAIL reset_e: got %b, expected 0", lcd_e); end
    n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b, expected 0", ready); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b, expected 1", busy); end
  endtask

  task automatic test_powerup(input string tag);
    logic [8:0] b;
    logic [8:0] exp_cmd [3];
    int rel, rdy, k;
    exp_cmd[0] = 9'h038; exp_cmd[1] = 9'h00C; exp_cmd[2] = 9'h001;
    @(negedge clk);
    reset = 1'b1;
    rel = cyc;
    for (int i = 0; i < 3; i++) begin
      get_byte(b);
      n_tests++;
      if (b !== exp_cmd[i]) begin
        n_fail++; $display("FAIL %s_init_cmd%0d: got rs/data %h, expected %h", tag, i, b, exp_cmd[i]);
      end
      if (i == 0) begin
        n_tests++;
        if (rise_cyc - rel < int'((PWRON + 1) * DIV) || rise_cyc - rel > int'((PWRON + 2) * DIV)) begin
          n_fail++; $display("FAIL %s_first_e: rose %0d cycles after release, expected %0d..%0d",
                             tag, rise_cyc - rel, (PWRON + 1) * DIV, (PWRON + 2) * DIV);
        end
      end
    end
    k = 0;
    while (ready !== 1'b1 && k < 2000) begin
      @(negedge clk); #1;
      k++;
    end
    rdy = cyc;
    n_tests++;
    if (ready !== 1'b1 || rdy - fall_cyc < int'(CLRW * DIV)) begin
      n_fail++; $display("FAIL %s_ready_delay: ready=%b %0d cycles after clear strobe, expected 1 after >= %0d",
                         tag, ready, rdy - fall_cyc, CLRW * DIV);
    end
    n_tests++;
    if (fall_cyc - rise_cyc != int'(DIV)) begin
      n_fail++; $display("FAIL %s_e_width: e high %0d cycles, expected %0d", tag, fall_cyc - rise_cyc, DIV);
    end
  endtask

  task automatic test_default_buffer(input string tag);
    logic [8:0] b, exp;
    for (int r = 0; r < ROWS; r++)
      for (int j = 0; j <= COLS; j++) begin
        get_byte(b);
        exp = (j == 0) ? ((r == 0) ? 9'h080 : 9'h0C0) : {1'b1, mdl[r][j-1]};
        n_tests++;
        if (b !== exp) begin
          n_fail++; $display("FAIL %s_row%0d_byte%0d: got rs/data %h, expected %h", tag, r, j, b, exp);
        end
      end
    wait_idle();
    n_tests++;
    if (busy !== 1'b0 || q.size() != 0) begin
      n_fail++; $display("FAIL %s_idle: busy=%b pending=%0d, expected busy=0 pending=0", tag, busy, q.size());
    end
  endtask

  task automatic test_write_idle();
    logic [8:0] b, exp;
    do_write(1, 3, 8'h41);
    for (int j = 0; j <= COLS; j++) begin
      get_byte(b);
      exp = (j == 0) ? 9'h0C0 : ((j == 4) ? 9'h141 : 9'h120);
      n_tests++;
      if (b !== exp) begin
        n_fail++; $display("FAIL write_idle_byte%0d: got rs/data %h, expected %h", j, b, exp);
      end
    end
    wait_idle();
    n_tests++;
    if (busy !== 1'b0 || q.size() != 0) begin
      n_fail++; $display("FAIL write_idle_only_row1: busy=%b pending=%0d, expected busy=0 pending=0", busy, q.size());
    end
  endtask

  task automatic test_invalid_write();
    logic saw_busy = 1'b0;
    do_write(2, 0, 8'h58);
    do_write(0, 16, 8'h59);
    do_write(3, 40, 8'h5A);
    repeat (300) begin
      @(negedge clk); #1;
      if (busy !== 1'b0) saw_busy = 1'b1;
    end
    n_tests++;
    if (saw_busy !== 1'b0 || q.size() != 0) begin
      n_fail++; $display("FAIL invalid_write: busy_seen=%b strobes=%0d, expected 0 and 0", saw_busy, q.size());
    end
  endtask

  task automatic test_refresh_collision();
    logic [8:0] b, exp;
    do_write(0, 1, 8'h42);
    for (int pass = 0; pass < 2; pass++)
      for (int j = 0; j <= COLS; j++) begin
        get_byte(b);
        exp = (j == 0) ? 9'h080 : {1'b1, mdl[0][j-1]};
        n_tests++;
        if (b !== exp) begin
          n_fail++; $display("FAIL collision_pass%0d_byte%0d: got rs/data %h, expected %h", pass, j, b, exp);
        end
        if (pass == 0 && j == 6) do_write(0, 15, 8'h5A);
      end
    n_tests++;
    if (mdl[0][15] !== 8'h5A || b !== 9'h15A) begin
      n_fail++; $display("FAIL collision_last_char: got rs/data %h, expected 15a", b);
    end
    wait_idle();
    n_tests++;
    if (busy !== 1'b0 || q.size() != 0) begin
      n_fail++; $display("FAIL collision_idle: busy=%b pending=%0d, expected busy=0 pending=0", busy, q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] b, exp;
    do_write(1, 0, 8'h51);
    for (int j = 0; j <= 9; j++) begin
      get_byte(b);
      exp = (j == 0) ? 9'h0C0 : {1'b1, mdl[1][j-1]};
      n_tests++;
      if (b !== exp) begin
        n_fail++; $display("FAIL midreset_pre_byte%0d: got rs/data %h, expected %h", j, b, exp);
      end
    end
    n_tests++;
    if (lcd_e !== 1'b1) begin n_fail++; $display("FAIL midreset_e_before: got %b, expected 1", lcd_e); end
    #2 reset = 1'b0;
    #1;
    n_tests++; if (lcd_e !== 1'b0) begin n_fail++; $display("FAIL midreset_e: got %b, expected 0", lcd_e); end
    n_tests++; if (lcd_data !== 8'h00) begin n_fail++; $display("FAIL midreset_data: got %h, expected 00", lcd_data); end
    n_tests++; if (lcd_rs !== 1'b0) begin n_fail++; $display("FAIL midreset_rs: got %b, expected 0", lcd_rs); end
    n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL midreset_ready: got %b, expected 0", ready); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midreset_busy: got %b, expected 1", busy); end
    repeat (3) @(negedge clk);
    model_clear();
    q.delete();
    test_powerup("reinit");
    test_default_buffer("reinit");
  endtask

  initial begin
    model_clear();
    test_reset();
    test_powerup("init");
    test_default_buffer("default");
    test_write_idle();
    test_invalid_write();
    test_refresh_collision();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded 1 ms");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

endmodule
